// File: rtl/mrv1_mt_pkg.sv
// Shared types and defaults for the mrv1 multithreaded front end.
package mrv1_mt_pkg;

  localparam int unsigned NUM_THREADS  = 8;
  localparam int unsigned NUM_BARRIERS = 4;
  localparam int unsigned TID_W        = $clog2(NUM_THREADS);
  localparam int unsigned BID_W        = $clog2(NUM_BARRIERS);
  localparam logic [31:0] STARTUP_PC   = 32'h0;

  typedef logic [TID_W-1:0] tid_t;
  typedef logic [BID_W-1:0] bid_t;

  typedef struct packed {
    logic        active;
    logic        locked;
    logic        stalled;
    logic        redirected;
    logic [31:0] pc;
  } thread_state_t;

endpackage

// File: rtl/mrv1_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr_i, wrapping (N_P power of two).
module mrv1_rr_arbiter #(
  parameter int unsigned N_P     = 8,
  parameter int unsigned IDX_W_P = $clog2(N_P)
) (
  input  logic [N_P-1:0]     req_i,
  input  logic [IDX_W_P-1:0] ptr_i,
  output logic [N_P-1:0]     gnt_o,
  output logic               vld_o,
  output logic [IDX_W_P-1:0] idx_o
);

  logic [IDX_W_P-1:0] cand;

  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_P; i++) begin
      cand = IDX_W_P'(ptr_i + IDX_W_P'(i));
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o = vld_o ? (N_P'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/mrv1_mt_sched.sv
// IMT thread scheduler: round-robin grant, per-thread PC/lock tracking, spawn/exit, barriers.
// Barrier support is built only when MRV1_MT_SCHED_BARRIER_EN is defined.
module mrv1_mt_sched
  import mrv1_mt_pkg::*;
#(
  parameter int unsigned NUM_THREADS_P  = 8,
  parameter int unsigned NUM_BARRIERS_P = 4,
  parameter logic [31:0] STARTUP_PC_P   = STARTUP_PC,
  localparam int unsigned tid_width_lp  = $clog2(NUM_THREADS_P),
  localparam int unsigned bid_width_lp  = (NUM_BARRIERS_P > 1) ? $clog2(NUM_BARRIERS_P) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sched_rdy_i,
  output logic                    sched_vld_o,
  output logic [tid_width_lp-1:0] sched_tid_o,
  output logic [31:0]             sched_pc_o,
  input  logic                    fetch_done_i,
  input  logic [tid_width_lp-1:0] fetch_tid_i,
  input  logic [31:0]             fetch_pc_i,
  input  logic                    dec_j_vld_i,
  input  logic [tid_width_lp-1:0] dec_tid_i,
  input  logic [31:0]             dec_j_pc_i,
  input  logic                    exec_b_vld_i,
  input  logic [tid_width_lp-1:0] exec_tid_i,
  input  logic [31:0]             exec_b_pc_i,
  input  logic                    wstall_vld_i,
  input  logic [tid_width_lp-1:0] wstall_tid_i,
  input  logic                    th_ctl_vld_i,
  input  logic [tid_width_lp-1:0] th_ctl_tid_i,
  input  logic                    th_ctl_tspawn_vld_i,
  input  logic [31:0]             th_ctl_tspawn_pc_i,
  input  logic                    th_ctl_exit_vld_i,
  input  logic                    th_ctl_barrier_vld_i,
  input  logic [bid_width_lp-1:0] th_ctl_barrier_id_i,
  input  logic [tid_width_lp-1:0] th_ctl_barrier_size_m1_i,
  output logic                    spawn_ack_o,
  output logic [tid_width_lp-1:0] spawn_tid_o,
  output logic                    spawn_full_o,
  output logic                    idle_o
);

  thread_state_t             th_q [NUM_THREADS_P];
  thread_state_t             th_d [NUM_THREADS_P];
  logic [tid_width_lp-1:0]   rr_ptr_q, rr_ptr_d;
  logic                      run_q;

  logic [NUM_THREADS_P-1:0]  active_v, ready_v, bwait_v, gnt_v;
  logic                      arb_vld, grant_fire, barrier_take, spawn_req, spawn_free;
  logic [tid_width_lp-1:0]   arb_idx, spawn_idx;

`ifdef MRV1_MT_SCHED_BARRIER_EN
  logic [NUM_THREADS_P-1:0]  bar_mask_q [NUM_BARRIERS_P];
  logic [NUM_THREADS_P-1:0]  bar_mask_d [NUM_BARRIERS_P];
  logic [tid_width_lp-1:0]   bar_cnt_q  [NUM_BARRIERS_P];
  logic [tid_width_lp-1:0]   bar_cnt_d  [NUM_BARRIERS_P];

  assign barrier_take = th_ctl_vld_i & ~th_ctl_exit_vld_i & th_ctl_barrier_vld_i;

  always_comb begin
    bwait_v = '0;
    for (int unsigned b = 0; b < NUM_BARRIERS_P; b++) bwait_v = bwait_v | bar_mask_q[b];
  end

  // Last arrival releases everyone and is itself never parked.
  always_comb begin
    bar_mask_d = bar_mask_q;
    bar_cnt_d  = bar_cnt_q;
    if (barrier_take) begin
      if (bar_cnt_q[th_ctl_barrier_id_i] == th_ctl_barrier_size_m1_i) begin
        bar_mask_d[th_ctl_barrier_id_i] = '0;
        bar_cnt_d[th_ctl_barrier_id_i]  = '0;
      end else begin
        bar_mask_d[th_ctl_barrier_id_i][th_ctl_tid_i] = 1'b1;
        bar_cnt_d[th_ctl_barrier_id_i] =
          tid_width_lp'(bar_cnt_q[th_ctl_barrier_id_i] + 1'b1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned b = 0; b < NUM_BARRIERS_P; b++) begin
        bar_mask_q[b] <= '0;
        bar_cnt_q[b]  <= '0;
      end
    end else begin
      bar_mask_q <= bar_mask_d;
      bar_cnt_q  <= bar_cnt_d;
    end
  end
`else
  logic unused_barrier;
  assign unused_barrier = ^{th_ctl_barrier_vld_i, th_ctl_barrier_id_i, th_ctl_barrier_size_m1_i};
  assign barrier_take   = 1'b0;
  assign bwait_v        = '0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_THREADS_P; i++) begin
      active_v[i] = th_q[i].active;
      ready_v[i]  = th_q[i].active & ~th_q[i].locked & ~th_q[i].stalled & ~bwait_v[i];
    end
  end

  mrv1_rr_arbiter #(.N_P(NUM_THREADS_P), .IDX_W_P(tid_width_lp)) u_arb (
    .req_i (ready_v),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_v),
    .vld_o (arb_vld),
    .idx_o (arb_idx)
  );

  logic unused_gnt;
  assign unused_gnt  = ^gnt_v;

  assign sched_vld_o = run_q & arb_vld;
  assign sched_tid_o = run_q ? arb_idx : '0;
  assign sched_pc_o  = run_q ? th_q[arb_idx].pc : '0;
  assign grant_fire  = sched_vld_o & sched_rdy_i;
  assign idle_o      = ~|active_v;

  // Lowest-index free slot for spawn.
  always_comb begin
    spawn_free = 1'b0;
    spawn_idx  = '0;
    for (int unsigned i = 0; i < NUM_THREADS_P; i++) begin
      if (!spawn_free && !active_v[i]) begin
        spawn_free = 1'b1;
        spawn_idx  = tid_width_lp'(i);
      end
    end
  end

  assign spawn_req    = run_q & th_ctl_vld_i & th_ctl_tspawn_vld_i & ~th_ctl_exit_vld_i & ~barrier_take;
  assign spawn_ack_o  = spawn_req & spawn_free;
  assign spawn_full_o = spawn_req & ~spawn_free;
  assign spawn_tid_o  = spawn_ack_o ? spawn_idx : '0;

  // Update order encodes priority: later writes win (exec > dec > fetch_done, redirect > wstall).
  always_comb begin
    th_d     = th_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_fire) begin
      th_d[arb_idx].locked     = 1'b1;
      th_d[arb_idx].redirected = 1'b0;
      rr_ptr_d                 = tid_width_lp'(arb_idx + 1'b1);
    end
    if (fetch_done_i) begin
      th_d[fetch_tid_i].locked = 1'b0;
      if (!th_q[fetch_tid_i].redirected) th_d[fetch_tid_i].pc = fetch_pc_i + 32'd4;
    end
    if (wstall_vld_i) th_d[wstall_tid_i].stalled = 1'b1;
    if (dec_j_vld_i) begin
      th_d[dec_tid_i].pc      = dec_j_pc_i;
      th_d[dec_tid_i].stalled = 1'b0;
      if (th_d[dec_tid_i].locked) th_d[dec_tid_i].redirected = 1'b1;
    end
    if (exec_b_vld_i) begin
      th_d[exec_tid_i].pc      = exec_b_pc_i;
      th_d[exec_tid_i].stalled = 1'b0;
      if (th_d[exec_tid_i].locked) th_d[exec_tid_i].redirected = 1'b1;
    end
    if (th_ctl_vld_i && th_ctl_exit_vld_i) begin
      th_d[th_ctl_tid_i].active = 1'b0;
      th_d[th_ctl_tid_i].locked = 1'b0;
    end else if (spawn_ack_o) begin
      th_d[spawn_idx] = '{active: 1'b1, locked: 1'b0, stalled: 1'b0,
                          redirected: 1'b0, pc: th_ctl_tspawn_pc_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_THREADS_P; i++) th_q[i] <= '0;
      th_q[0]  <= '{active: 1'b1, locked: 1'b0, stalled: 1'b0,
                    redirected: 1'b0, pc: STARTUP_PC_P};
      rr_ptr_q <= '0;
      run_q    <= 1'b0;
    end else begin
      th_q     <= th_d;
      rr_ptr_q <= rr_ptr_d;
      run_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mrv1_mt_sched.sv
// Directed self-checking bench for mrv1_mt_sched (8 threads, 4 barriers).
module tb_mrv1_mt_sched;

`ifdef MRV1_MT_SCHED_BARRIER_EN
  localparam bit BAR_EN = 1'b1;
`else
  localparam bit BAR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        sched_rdy_i, sched_vld_o;
  logic [2:0]  sched_tid_o;
  logic [31:0] sched_pc_o;
  logic        fetch_done_i;
  logic [2:0]  fetch_tid_i;
  logic [31:0] fetch_pc_i;
  logic        dec_j_vld_i;
  logic [2:0]  dec_tid_i;
  logic [31:0] dec_j_pc_i;
  logic        exec_b_vld_i;
  logic [2:0]  exec_tid_i;
  logic [31:0] exec_b_pc_i;
  logic        wstall_vld_i;
  logic [2:0]  wstall_tid_i;
  logic        th_ctl_vld_i;
  logic [2:0]  th_ctl_tid_i;
  logic        th_ctl_tspawn_vld_i;
  logic [31:0] th_ctl_tspawn_pc_i;
  logic        th_ctl_exit_vld_i;
  logic        th_ctl_barrier_vld_i;
  logic [1:0]  th_ctl_barrier_id_i;
  logic [2:0]  th_ctl_barrier_size_m1_i;
  logic        spawn_ack_o, spawn_full_o, idle_o;
  logic [2:0]  spawn_tid_o;

  int n_tests = 0;
  int n_fail  = 0;

  mrv1_mt_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sched_rdy_i(sched_rdy_i),
    .sched_vld_o(sched_vld_o), .sched_tid_o(sched_tid_o), .sched_pc_o(sched_pc_o),
    .fetch_done_i(fetch_done_i), .fetch_tid_i(fetch_tid_i), .fetch_pc_i(fetch_pc_i),
    .dec_j_vld_i(dec_j_vld_i), .dec_tid_i(dec_tid_i), .dec_j_pc_i(dec_j_pc_i),
    .exec_b_vld_i(exec_b_vld_i), .exec_tid_i(exec_tid_i), .exec_b_pc_i(exec_b_pc_i),
    .wstall_vld_i(wstall_vld_i), .wstall_tid_i(wstall_tid_i),
    .th_ctl_vld_i(th_ctl_vld_i), .th_ctl_tid_i(th_ctl_tid_i),
    .th_ctl_tspawn_vld_i(th_ctl_tspawn_vld_i), .th_ctl_tspawn_pc_i(th_ctl_tspawn_pc_i),
    .th_ctl_exit_vld_i(th_ctl_exit_vld_i), .th_ctl_barrier_vld_i(th_ctl_barrier_vld_i),
    .th_ctl_barrier_id_i(th_ctl_barrier_id_i), .th_ctl_barrier_size_m1_i(th_ctl_barrier_size_m1_i),
    .spawn_ack_o(spawn_ack_o), .spawn_tid_o(spawn_tid_o), .spawn_full_o(spawn_full_o),
    .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    sched_rdy_i = 0; fetch_done_i = 0; fetch_tid_i = 0; fetch_pc_i = 0;
    dec_j_vld_i = 0; dec_tid_i = 0; dec_j_pc_i = 0;
    exec_b_vld_i = 0; exec_tid_i = 0; exec_b_pc_i = 0;
    wstall_vld_i = 0; wstall_tid_i = 0;
    th_ctl_vld_i = 0; th_ctl_tid_i = 0; th_ctl_tspawn_vld_i = 0; th_ctl_tspawn_pc_i = 0;
    th_ctl_exit_vld_i = 0; th_ctl_barrier_vld_i = 0; th_ctl_barrier_id_i = 0;
    th_ctl_barrier_size_m1_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic grant_one(input logic [2:0] tid, input logic [31:0] pc);
    check($sformatf("gnt_vld_t%0d", tid), 32'(sched_vld_o), 32'd1);
    check($sformatf("gnt_tid_t%0d", tid), 32'(sched_tid_o), 32'(tid));
    check($sformatf("gnt_pc_t%0d", tid), sched_pc_o, pc);
    sched_rdy_i = 1'b1;
    tick();
    sched_rdy_i = 1'b0;
  endtask

  task automatic fdone(input logic [2:0] tid, input logic [31:0] pc);
    fetch_done_i = 1'b1; fetch_tid_i = tid; fetch_pc_i = pc;
    tick();
    clr();
  endtask

  task automatic spawn_chk(input logic [31:0] pc, input logic ack, input logic [2:0] tid, input logic full);
    th_ctl_vld_i = 1'b1; th_ctl_tspawn_vld_i = 1'b1; th_ctl_tspawn_pc_i = pc;
    #1;
    check("spawn_ack", 32'(spawn_ack_o), 32'(ack));
    check("spawn_tid", 32'(spawn_tid_o), 32'(tid));
    check("spawn_full", 32'(spawn_full_o), 32'(full));
    tick();
    clr();
  endtask

  task automatic ctl_op(input logic [2:0] tid, input logic is_exit, input logic is_bar);
    th_ctl_vld_i = 1'b1; th_ctl_tid_i = tid;
    th_ctl_exit_vld_i = is_exit; th_ctl_barrier_vld_i = is_bar;
    th_ctl_barrier_id_i = 2'd1; th_ctl_barrier_size_m1_i = 3'd2;
    tick();
    clr();
  endtask

  initial begin
    clr();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_vld", 32'(sched_vld_o), 32'd0);
    check("rst_tid", 32'(sched_tid_o), 32'd0);
    check("rst_pc", sched_pc_o, 32'd0);
    check("rst_idle", 32'(idle_o), 32'd0);
    th_ctl_vld_i = 1'b1; th_ctl_tspawn_vld_i = 1'b1; th_ctl_tspawn_pc_i = 32'h100;
    #1;
    check("rst_spawn_ack", 32'(spawn_ack_o), 32'd0);
    check("rst_spawn_full", 32'(spawn_full_o), 32'd0);
    clr();
    rst_ni = 1'b1;
    #1;
    check("prerun_vld", 32'(sched_vld_o), 32'd0);
    tick();

    // single thread: one grant, locked until fetch completes, pc advances by 4
    grant_one(3'd0, 32'h0);
    check("locked_vld", 32'(sched_vld_o), 32'd0);
    tick();
    check("locked_vld2", 32'(sched_vld_o), 32'd0);
    fdone(3'd0, 32'h0);
    grant_one(3'd0, 32'h4);

    // spawn fills threads 1..7, then full
    for (int k = 0; k < 7; k++) spawn_chk(32'h100, 1'b1, 3'(k + 1), 1'b0);
    spawn_chk(32'h100, 1'b0, 3'd0, 1'b1);
    check("busy_idle", 32'(idle_o), 32'd0);

    for (int k = 1; k < 8; k++) grant_one(3'(k), 32'h100);
    check("all_locked_vld", 32'(sched_vld_o), 32'd0);
    fdone(3'd0, 32'h4);
    for (int k = 1; k < 8; k++) fdone(3'(k), 32'h100);
    grant_one(3'd0, 32'h8);
    grant_one(3'd1, 32'h104);
    grant_one(3'd2, 32'h104);

    // branch redirect on a locked thread survives its fetch_done
    exec_b_vld_i = 1'b1; exec_tid_i = 3'd2; exec_b_pc_i = 32'h200;
    tick(); clr();
    fdone(3'd2, 32'h40);
    for (int k = 3; k < 8; k++) grant_one(3'(k), 32'h104);
    grant_one(3'd2, 32'h200);
    check("all_locked_vld2", 32'(sched_vld_o), 32'd0);

    // exec beats dec on the same thread
    dec_j_vld_i = 1'b1; dec_tid_i = 3'd1; dec_j_pc_i = 32'h10;
    exec_b_vld_i = 1'b1; exec_tid_i = 3'd1; exec_b_pc_i = 32'h20;
    tick(); clr();
    fdone(3'd1, 32'h104);
    grant_one(3'd1, 32'h20);

    // redirect beats fetch_done in the same cycle
    fetch_done_i = 1'b1; fetch_tid_i = 3'd3; fetch_pc_i = 32'h104;
    dec_j_vld_i = 1'b1; dec_tid_i = 3'd3; dec_j_pc_i = 32'h300;
    tick(); clr();
    grant_one(3'd3, 32'h300);

    for (int k = 1; k < 8; k++) ctl_op(3'(k), 1'b1, 1'b0);
    fdone(3'd0, 32'h8);
    check("solo_vld", 32'(sched_vld_o), 32'd1);
    check("solo_pc", sched_pc_o, 32'hC);

    // wait-stall parks the thread, a same-cycle redirect wins
    wstall_vld_i = 1'b1; wstall_tid_i = 3'd0;
    tick(); clr();
    check("wstall_vld", 32'(sched_vld_o), 32'd0);
    check("wstall_idle", 32'(idle_o), 32'd0);
    wstall_vld_i = 1'b1; wstall_tid_i = 3'd0;
    dec_j_vld_i = 1'b1; dec_tid_i = 3'd0; dec_j_pc_i = 32'h50;
    tick(); clr();
    check("unstall_vld", 32'(sched_vld_o), 32'd1);
    check("unstall_pc", sched_pc_o, 32'h50);

    // exit has priority over spawn; last exit makes the core idle
    th_ctl_vld_i = 1'b1; th_ctl_tid_i = 3'd0; th_ctl_exit_vld_i = 1'b1;
    th_ctl_tspawn_vld_i = 1'b1; th_ctl_tspawn_pc_i = 32'h900;
    #1;
    check("exit_spawn_ack", 32'(spawn_ack_o), 32'd0);
    check("exit_spawn_full", 32'(spawn_full_o), 32'd0);
    tick(); clr();
    check("exit_idle", 32'(idle_o), 32'd1);
    check("exit_vld", 32'(sched_vld_o), 32'd0);

    // barrier id1, three participants; rr pointer sits at 4
    for (int k = 0; k < 3; k++) spawn_chk(32'h400, 1'b1, 3'(k), 1'b0);
    check("bar_idle", 32'(idle_o), 32'd0);
    ctl_op(3'd0, 1'b0, 1'b1);
    check("bar1_vld", 32'(sched_vld_o), 32'd1);
    check("bar1_tid", 32'(sched_tid_o), BAR_EN ? 32'd1 : 32'd0);
    ctl_op(3'd1, 1'b0, 1'b1);
    check("bar2_tid", 32'(sched_tid_o), BAR_EN ? 32'd2 : 32'd0);
    ctl_op(3'd2, 1'b0, 1'b1);
    grant_one(3'd0, 32'h400);
    grant_one(3'd1, 32'h400);
    grant_one(3'd2, 32'h400);

    // reset mid-operation restores the startup state
    rst_ni = 1'b0;
    #1;
    check("rst2_vld", 32'(sched_vld_o), 32'd0);
    rst_ni = 1'b1;
    tick();
    check("rst2_idle", 32'(idle_o), 32'd0);
    grant_one(3'd0, 32'h0);
    check("rst2_solo", 32'(sched_vld_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
